// File: rtl/ifq_pkg.sv
// ---------------------------------------------------------------------------
// ifq_pkg
// Shared types and constants for the instruction fetch queue.
//   ifq_state_e  : fetch FSM states (IDLE, WAIT, DROP)
//   WORD_BYTES   : byte stride between consecutive instruction words
//   PERF_W       : width of the optional performance counters
//   ifq_entry_t  : one buffered fetch result {pc, instr} at the default
//                  32-bit address/data widths
// ---------------------------------------------------------------------------
package ifq_pkg;

    // IDLE: no request outstanding.
    // WAIT: request outstanding, its response will be kept.
    // DROP: request outstanding, its response will be thrown away.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } ifq_state_e;

    localparam int WORD_BYTES    = 4;
    localparam int PERF_W        = 16;
    localparam int ENTRY_PC_W    = 32;
    localparam int ENTRY_INSTR_W = 32;

    typedef struct packed {
        logic [ENTRY_PC_W-1:0]    pc;
        logic [ENTRY_INSTR_W-1:0] instr;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// ---------------------------------------------------------------------------
// ifq_fifo
// Circular buffer holding fetched {pc, instr} entries for the fetch queue.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write one entry at the tail
//   pop_i         : retire the head entry (ignored when empty)
//   flush_i       : empty the buffer; wins over push and pop
//   head_o        : combinational view of the head entry
//   count_o       : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module ifq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rptr_q;
    logic [PW-1:0]    wptr_q;
    logic [PW:0]      count_q;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= wptr_q + PW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            if (push_i && !do_pop) begin
                count_q <= count_q + (PW+1)'(1);
            end else if (!push_i && do_pop) begin
                count_q <= count_q - (PW+1)'(1);
            end
        end
    end

    // The fetch FSM only issues when a slot is free, so a push into a full
    // buffer means the issue logic is broken.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push_i && !flush_i) begin
            assert (count_q < (PW+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
// Fetch stage: owns the fetch PC, issues one word read at a time to a
// variable-latency instruction memory, buffers the returned words with
// their PCs and hands them to decode. A redirect flushes the buffer,
// discards any in-flight response and restarts fetch at the new PC.
// Ports:
//   clk_i, rst_i              : clock, asynchronous active-low reset
//   redirect_i/redirect_pc_i  : flush and restart at redirect_pc_i (word aligned)
//   mem_req_o/mem_addr_o      : read request, address held until mem_ack_i
//   mem_ack_i/mem_data_i      : read completion and data
//   instr_valid_o/instr_o/instr_pc_o/instr_ready_i : decode handshake
//   count_o                   : buffer occupancy
// Optional build macro IFQ_PERF_EN adds stall_cnt_o and drop_cnt_o
// saturating event counters.
// ---------------------------------------------------------------------------
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   redirect_i,
    input  logic [ADDR_W-1:0]      redirect_pc_i,
    output logic                   mem_req_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic [DATA_W-1:0]      mem_data_i,
    output logic                   instr_valid_o,
    output logic [DATA_W-1:0]      instr_o,
    output logic [ADDR_W-1:0]      instr_pc_o,
    input  logic                   instr_ready_i,
    output logic [$clog2(DEPTH):0] count_o
`ifdef IFQ_PERF_EN
    ,
    output logic [PERF_W-1:0]      stall_cnt_o,
    output logic [PERF_W-1:0]      drop_cnt_o
`endif
);

    localparam int                CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);

    ifq_state_e               state_q;
    logic [ADDR_W-1:0]        fpc_q;
    logic [ADDR_W-1:0]        req_addr_q;
    logic [ADDR_W-1:0]        fpc_inc;
    logic [ADDR_W-1:0]        redirect_pc;
    logic                     push;
    logic                     pop;
    logic                     room_after;
    logic [CNT_W-1:0]         count;
    logic [ADDR_W+DATA_W-1:0] head;
    logic                     unused_pc_bits;

    assign redirect_pc    = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc_i[1:0];
    assign fpc_inc        = fpc_q + ADDR_W'(WORD_BYTES);

    // Redirect outranks both push and pop: the flush empties the buffer.
    assign pop  = instr_valid_o && instr_ready_i && !redirect_i;
    assign push = (state_q == WAIT) && mem_ack_i && !redirect_i;

    // Occupancy once this cycle's push and pop have landed; decides whether
    // the next word can be requested straight away.
    assign room_after = (count + CNT_W'(1) - CNT_W'(pop)) < FULL;

    ifq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_i),
        .push_i  (push),
        .data_i  ({req_addr_q, mem_data_i}),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .head_o  (head),
        .count_o (count)
    );

    assign instr_pc_o    = head[ADDR_W+DATA_W-1:DATA_W];
    assign instr_o       = head[DATA_W-1:0];
    assign instr_valid_o = (count != '0);
    assign count_o       = count;
    assign mem_req_o     = (state_q != IDLE);
    assign mem_addr_o    = req_addr_q;

    // Fetch FSM. The request address only changes when a new request is
    // issued, so it stays put for as long as a request is outstanding,
    // including while its response is being dropped.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            fpc_q      <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect_i) begin
                        fpc_q <= redirect_pc;
                    end else if (count < FULL) begin
                        req_addr_q <= fpc_q;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_i) begin
                        fpc_q <= redirect_pc;
                        if (mem_ack_i) begin
                            req_addr_q <= redirect_pc;
                        end else begin
                            state_q <= DROP;
                        end
                    end else if (mem_ack_i) begin
                        fpc_q <= fpc_inc;
                        if (room_after) begin
                            req_addr_q <= fpc_inc;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (redirect_i) begin
                        fpc_q <= redirect_pc;
                    end
                    if (mem_ack_i) begin
                        req_addr_q <= redirect_i ? redirect_pc : fpc_q;
                        state_q    <= WAIT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef IFQ_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] drop_cnt_q;
    logic              drop_evt;

    assign drop_evt = mem_ack_i &&
                      ((state_q == DROP) || ((state_q == WAIT) && redirect_i));

    // Saturating counters: decode starved, and responses thrown away.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (instr_ready_i && !instr_valid_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            if (drop_evt && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + PERF_W'(1);
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_queue
// Directed scenarios for the fetch queue followed by a randomized run that
// is checked against a queue-based model of the fetch stream.
// ---------------------------------------------------------------------------
module tb_instr_fetch_queue;
    import ifq_pkg::*;

    localparam int          DEPTH = 4;
    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam logic [31:0] K     = 32'hA5A5_0000;

    logic          clk = 1'b0;
    logic          rstN = 1'b1;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirectPc = '0;
    logic          memReq;
    logic [AW-1:0] memAddr;
    logic          memAck = 1'b0;
    logic [DW-1:0] memData = '0;
    logic          instrValid;
    logic [DW-1:0] instr;
    logic [AW-1:0] instrPc;
    logic          instrReady = 1'b0;
    logic [2:0]    count;
`ifdef IFQ_PERF_EN
    logic [15:0]   stallCnt;
    logic [15:0]   dropCnt;
`endif

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .RESET_PC (32'h0)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rstN),
        .redirect_i    (redirect),
        .redirect_pc_i (redirectPc),
        .mem_req_o     (memReq),
        .mem_addr_o    (memAddr),
        .mem_ack_i     (memAck),
        .mem_data_i    (memData),
        .instr_valid_o (instrValid),
        .instr_o       (instr),
        .instr_pc_o    (instrPc),
        .instr_ready_i (instrReady),
        .count_o       (count)
`ifdef IFQ_PERF_EN
        ,
        .stall_cnt_o   (stallCnt),
        .drop_cnt_o    (dropCnt)
`endif
    );

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across two edges and release it mid-cycle.
    task automatic doReset();
        rstN       = 1'b0;
        redirect   = 1'b0;
        redirectPc = '0;
        memAck     = 1'b0;
        memData    = '0;
        instrReady = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        rstN = 1'b0;
        #1;
        checkCount++;
        if (memReq !== 1'b0) $display("[TB] FAIL reset_req: got %0b expected 0", memReq); else passCount++;
        checkCount++;
        if (memAddr !== 32'h0) $display("[TB] FAIL reset_addr: got %h expected 0", memAddr); else passCount++;
        checkCount++;
        if (instrValid !== 1'b0) $display("[TB] FAIL reset_valid: got %0b expected 0", instrValid); else passCount++;
        checkCount++;
        if (instr !== 32'h0 || instrPc !== 32'h0)
            $display("[TB] FAIL reset_head: got instr %h pc %h expected 0 0", instr, instrPc);
        else passCount++;
        checkCount++;
        if (count !== 3'd0) $display("[TB] FAIL reset_count: got %0d expected 0", count); else passCount++;
        doReset();
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        doReset();
        instrReady = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            exp = 32'(i * 4);
            checkCount++;
            if (memReq !== 1'b1 || memAddr !== exp)
                $display("[TB] FAIL stream_addr%0d: got req %0b addr %h expected 1 %h", i, memReq, memAddr, exp);
            else passCount++;
            memAck  = 1'b1;
            memData = exp ^ K;
            tick();
            memAck = 1'b0;
            checkCount++;
            if (instrValid !== 1'b1 || instrPc !== exp || instr !== (exp ^ K))
                $display("[TB] FAIL stream_head%0d: got v %0b pc %h instr %h expected 1 %h %h",
                         i, instrValid, instrPc, instr, exp, exp ^ K);
            else passCount++;
            tick();
        end
    endtask

    task automatic test_full();
        doReset();
        instrReady = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checkCount++;
            if (memAddr !== 32'(i * 4)) $display("[TB] FAIL full_addr%0d: got %h expected %h", i, memAddr, 32'(i * 4));
            else passCount++;
            memAck  = 1'b1;
            memData = 32'(i * 4) ^ K;
            tick();
        end
        memAck = 1'b0;
        checkCount++;
        if (count !== 3'd4 || memReq !== 1'b0)
            $display("[TB] FAIL full_stop: got count %0d req %0b expected 4 0", count, memReq);
        else passCount++;
        checkCount++;
        if (instrPc !== 32'h0) $display("[TB] FAIL full_head: got %h expected 0", instrPc); else passCount++;
        instrReady = 1'b1;
        tick();
        instrReady = 1'b0;
        checkCount++;
        if (count !== 3'd3 || instrPc !== 32'h4)
            $display("[TB] FAIL full_pop: got count %0d pc %h expected 3 00000004", count, instrPc);
        else passCount++;
        tick();
        checkCount++;
        if (memReq !== 1'b1 || memAddr !== 32'h10)
            $display("[TB] FAIL full_resume: got req %0b addr %h expected 1 00000010", memReq, memAddr);
        else passCount++;
    endtask

    task automatic test_redirect_wait();
        doReset();
        tick();
        memAck  = 1'b1;
        memData = K;
        tick();
        memData = 32'h4 ^ K;
        tick();
        memAck = 1'b0;
        checkCount++;
        if (memAddr !== 32'h8) $display("[TB] FAIL rdw_setup: got %h expected 00000008", memAddr); else passCount++;
        redirect   = 1'b1;
        redirectPc = 32'h100;
        tick();
        redirect = 1'b0;
        checkCount++;
        if (memReq !== 1'b1 || memAddr !== 32'h8 || count !== 3'd0 || instrValid !== 1'b0)
            $display("[TB] FAIL rdw_hold: got req %0b addr %h count %0d v %0b expected 1 00000008 0 0",
                     memReq, memAddr, count, instrValid);
        else passCount++;
        tick();
        checkCount++;
        if (memReq !== 1'b1 || memAddr !== 32'h8)
            $display("[TB] FAIL rdw_hold2: got req %0b addr %h expected 1 00000008", memReq, memAddr);
        else passCount++;
        memAck  = 1'b1;
        memData = 32'hDEAD_BEEF;
        tick();
        memAck = 1'b0;
        checkCount++;
        if (memAddr !== 32'h100 || count !== 3'd0)
            $display("[TB] FAIL rdw_drop: got addr %h count %0d expected 00000100 0", memAddr, count);
        else passCount++;
        memAck  = 1'b1;
        memData = 32'h100 ^ K;
        tick();
        memAck = 1'b0;
        checkCount++;
        if (instrValid !== 1'b1 || instrPc !== 32'h100 || instr !== (32'h100 ^ K))
            $display("[TB] FAIL rdw_first: got v %0b pc %h instr %h expected 1 00000100 %h",
                     instrValid, instrPc, instr, 32'h100 ^ K);
        else passCount++;
    endtask

    task automatic test_redirect_ack();
        doReset();
        tick();
        memAck  = 1'b1;
        memData = K;
        tick();
        memData    = 32'h4 ^ K;
        redirect   = 1'b1;
        redirectPc = 32'h200;
        tick();
        memAck   = 1'b0;
        redirect = 1'b0;
        checkCount++;
        if (count !== 3'd0 || instrValid !== 1'b0)
            $display("[TB] FAIL rda_flush: got count %0d v %0b expected 0 0", count, instrValid);
        else passCount++;
        checkCount++;
        if (memReq !== 1'b1 || memAddr !== 32'h200)
            $display("[TB] FAIL rda_addr: got req %0b addr %h expected 1 00000200", memReq, memAddr);
        else passCount++;
    endtask

    task automatic test_full_redirect();
        doReset();
        tick();
        memAck = 1'b1;
        for (int i = 0; i < 4; i++) begin
            memData = 32'(i);
            tick();
        end
        memAck = 1'b0;
        checkCount++;
        if (count !== 3'd4) $display("[TB] FAIL fr_fill: got %0d expected 4", count); else passCount++;
        redirect   = 1'b1;
        redirectPc = 32'h303;
        instrReady = 1'b1;
        tick();
        redirect   = 1'b0;
        instrReady = 1'b0;
        checkCount++;
        if (count !== 3'd0 || instrValid !== 1'b0 || memReq !== 1'b0)
            $display("[TB] FAIL fr_flush: got count %0d v %0b req %0b expected 0 0 0", count, instrValid, memReq);
        else passCount++;
        tick();
        checkCount++;
        if (memReq !== 1'b1 || memAddr !== 32'h300)
            $display("[TB] FAIL fr_restart: got req %0b addr %h expected 1 00000300", memReq, memAddr);
        else passCount++;
    endtask

    task automatic test_reset_wait();
        doReset();
        tick();
        memAck = 1'b1;
        repeat (3) tick();
        memAck = 1'b0;
        checkCount++;
        if (memReq !== 1'b1 || memAddr !== 32'hC)
            $display("[TB] FAIL rw_setup: got req %0b addr %h expected 1 0000000c", memReq, memAddr);
        else passCount++;
        rstN = 1'b0;
        #1;
        checkCount++;
        if (memReq !== 1'b0 || instrValid !== 1'b0 || count !== 3'd0 || memAddr !== 32'h0)
            $display("[TB] FAIL rw_async: got req %0b v %0b count %0d addr %h expected 0 0 0 0",
                     memReq, instrValid, count, memAddr);
        else passCount++;
        #2;
        rstN = 1'b1;
        tick();
        checkCount++;
        if (memReq !== 1'b1 || memAddr !== 32'h0)
            $display("[TB] FAIL rw_restart: got req %0b addr %h expected 1 0", memReq, memAddr);
        else passCount++;
    endtask

    task automatic test_wrap();
        doReset();
        instrReady = 1'b0;
        redirect   = 1'b1;
        redirectPc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        checkCount++;
        if (memReq !== 1'b0) $display("[TB] FAIL wrap_idle: got req %0b expected 0", memReq); else passCount++;
        tick();
        checkCount++;
        if (memAddr !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_issue: got %h expected fffffffc", memAddr);
        else passCount++;
        memAck  = 1'b1;
        memData = 32'h1234_5678;
        tick();
        memAck = 1'b0;
        checkCount++;
        if (memAddr !== 32'h0 || instrPc !== 32'hFFFF_FFFC || instr !== 32'h1234_5678)
            $display("[TB] FAIL wrap_next: got addr %h pc %h instr %h expected 0 fffffffc 12345678",
                     memAddr, instrPc, instr);
        else passCount++;
    endtask

    // Model: the buffer holds the in-order fetch stream since the last
    // redirect; any response to a request that was outstanding when a
    // redirect arrived is thrown away.
    task automatic test_random();
        ifq_entry_t  q[$];
        ifq_entry_t  e;
        logic [31:0] tail;
        logic        stale;
        logic        mreq;
        logic [31:0] maddr;
        doReset();
        tail  = 32'h0;
        stale = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checkCount++;
            if (count !== 3'(q.size()) || instrValid !== (q.size() != 0))
                $display("[TB] FAIL rnd_count c%0d: got count %0d v %0b expected %0d", cyc, count, instrValid, q.size());
            else passCount++;
            if (q.size() != 0) begin
                checkCount++;
                if (instrPc !== q[0].pc || instr !== q[0].instr)
                    $display("[TB] FAIL rnd_head c%0d: got pc %h instr %h expected %h %h",
                             cyc, instrPc, instr, q[0].pc, q[0].instr);
                else passCount++;
            end
            mreq  = memReq;
            maddr = memAddr;
            if (mreq && !stale) begin
                checkCount++;
                if (maddr !== tail) $display("[TB] FAIL rnd_addr c%0d: got %h expected %h", cyc, maddr, tail);
                else passCount++;
            end
            redirect   = ($urandom_range(0, 15) == 0);
            redirectPc = $urandom;
            instrReady = ($urandom_range(0, 9) < 7);
            memAck     = mreq && ($urandom_range(0, 1) == 1);
            memData    = $urandom;
            if (redirect) begin
                q.delete();
                tail = redirectPc & 32'hFFFF_FFFC;
                if (mreq) stale = !memAck;
            end else begin
                if (instrReady && q.size() != 0) e = q.pop_front();
                if (mreq && memAck) begin
                    if (stale) begin
                        stale = 1'b0;
                    end else begin
                        e.pc    = maddr;
                        e.instr = memData;
                        q.push_back(e);
                        tail = tail + 32'd4;
                    end
                end
            end
            tick();
        end
        redirect   = 1'b0;
        memAck     = 1'b0;
        instrReady = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_wait();
        test_redirect_ack();
        test_full_redirect();
        test_reset_wait();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage that sits directly upstream of the CPU decode path.
- Owns the fetch PC and issues word reads to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small FIFO and presents them to decode with valid/ready.
- On a branch/jump redirect it flushes the FIFO, discards any in-flight response and restarts fetch at the new PC.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 32, PC/address width.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- redirect_i  in  1  flush and restart fetch.
- redirect_pc_i  in  ADDR_W  new fetch PC; sampled when redirect_i=1.
- mem_req_o  out  1  read request.
- mem_addr_o  out  ADDR_W  read address; stable while mem_req_o=1.
- mem_ack_i  in  1  read data valid; completes the request.
- mem_data_i  in  DATA_W  read data; sampled when mem_ack_i=1.
- instr_valid_o  out  1  head entry valid.
- instr_o  out  DATA_W  head instruction.
- instr_pc_o  out  ADDR_W  PC of the head instruction.
- instr_ready_i  in  1  decode consumes head when valid&ready.
- count_o  out  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_i=0, immediate):
  - fpc=RESET_PC, state=IDLE, count=0, read/write pointers=0, storage cleared to 0.
  - mem_req_o=0, mem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0.
- State machine: IDLE, WAIT, DROP. At most one request outstanding.
- mem_req_o = (state==WAIT || state==DROP). mem_addr_o = req_addr register, loaded only on issue.
- IDLE:
  - If redirect_i: fpc<=redirect_pc_i; remain IDLE.
  - Else if count<DEPTH: req_addr<=fpc; go to WAIT.
- WAIT:
  - Redirect with no ack: flush; fpc<=redirect_pc_i; go to DROP. mem_req_o and mem_addr_o stay held; a request is never withdrawn before ack.
  - Redirect with ack in the same cycle: data discarded; flush; fpc<=redirect_pc_i; req_addr<=redirect_pc_i; stay in WAIT.
  - Ack without redirect: push {req_addr, mem_data_i}; fpc<=fpc+4. If occupancy after push and this cycle's pop is below DEPTH, req_addr<=fpc+4 and stay in WAIT (back-to-back fetch). Otherwise go to IDLE.
- DROP:
  - Ack: data discarded; req_addr<=fpc; go to WAIT.
  - Redirect: fpc<=redirect_pc_i; stay in DROP. If ack and redirect coincide, both apply: the new fpc is issued.
- Pop: when instr_valid_o && instr_ready_i, the read pointer advances.
- Push and pop in the same cycle: count unchanged.
- Push is only possible if a slot was free at issue. Overflow is impossible by construction; an assertion checks it.
- Redirect has priority over push and pop. Flush sets pointers and count to 0; instr_valid_o=0 in the following cycle.
- instr_valid_o = (count!=0). instr_o and instr_pc_o are combinational reads of the head entry.
- Pointers wrap modulo DEPTH. fpc increments modulo 2^ADDR_W; 0xFFFF_FFFC wraps to 0.
- Redirect PC bits [1:0] are forced to 0.

Optional Feature:
- Macro: IFQ_PERF_EN.
- When defined, two output ports are added:
  - stall_cnt_o (16-bit): increments each cycle instr_ready_i=1 && instr_valid_o=0.
  - drop_cnt_o (16-bit): increments for each discarded response (ack in DROP, or ack coinciding with redirect).
  - Both counters saturate at 16'hFFFF and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package ifq_pkg: state enum {IDLE, WAIT, DROP}, WORD_BYTES=4, the entry struct {pc, instr}, and the PERF counter width=16.
- Sub-module ifq_fifo: parameterised storage, pointers and count, with push, pop and flush inputs. The FSM stays in the top module.

Test Plan:
- Reset, ready=1, memory acks 1 cycle after req with data=addr^32'hA5A5_0000 -> mem_addr_o sequence 0,4,8,C; instr_pc_o matches each address; instr_o=pc^A5A50000.
- ready=0, immediate acks -> 4 entries pushed, count_o=4, mem_req_o=0 after the 4th ack; ready=1 for one cycle -> count_o=3, new req to 0x10.
- In WAIT at addr 0x8 with no ack, redirect to 0x100 -> mem_req_o stays 1 at 0x8; ack with 0xDEAD_BEEF is dropped; next req at 0x100; first valid instr_pc_o=0x100.
- Redirect to 0x200 in the same cycle as ack at 0x4 -> data not pushed; count_o=0 next cycle; next mem_addr_o=0x200.
- FIFO full with redirect_i and instr_ready_i high together -> count_o=0, instr_valid_o=0 next cycle, fetch restarts at the redirect PC.
- rst_i low while in WAIT at addr 0xC -> mem_req_o=0 and instr_valid_o=0 immediately; after release, first req at RESET_PC.
